univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the register width in bits; legal range WIDTH >= 2.
REQ-002 The module SHALL have derived localparam CW = $clog2(WIDTH), meaning the shift-counter width.
REQ-003 The module SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  meaning synchronous, active-low reset.
REQ-005 The module SHALL have port en_i  input  1  meaning operation enable; 0 freezes all state.
REQ-006 The module SHALL have port mode_i  input  3  meaning operation select, per REQ-011.
REQ-007 The module SHALL have ports ser_l_i and ser_r_i  input  1 each  meaning serial fill bits; ser_l_i enters at MSB, ser_r_i enters at LSB.
REQ-008 The module SHALL have port data_i  input  WIDTH  meaning parallel load value.
REQ-009 The module SHALL have ports sr_o  output  WIDTH (register contents), ser_l_o  output  1 (= sr_o[WIDTH-1]) and ser_r_o  output  1 (= sr_o[0]).
REQ-010 The module SHALL have ports cnt_o  output  CW (shifts completed in the current frame) and frame_o  output  1 (one-cycle frame-complete pulse).

Function
REQ-011 mode_i SHALL decode as: 0 hold; 1 SHL {sr[W-2:0],ser_r_i}; 2 SHR {ser_l_i,sr[W-1:1]}; 3 ROTL {sr[W-2:0],sr[W-1]}; 4 ROTR {sr[0],sr[W-1:1]}; 5 LOAD data_i; 6 ASR {sr[W-1],sr[W-1:1]}; 7 CLEAR to 0.
REQ-012 sr_o, cnt_o and frame_o SHALL all be registered; ser_l_o and ser_r_o SHALL be combinational taps of the register with no added latency.
REQ-013 A mode's result SHALL appear on sr_o one clk edge after it is sampled with en_i=1 (latency 1).
REQ-014 en_i=0 SHALL hold sr_o and cnt_o unchanged and SHALL drive frame_o to 0 at that edge, for any mode_i.
REQ-015 Shift modes 1, 2, 3, 4 and 6 with en_i=1 SHALL increment cnt_o by 1.
REQ-016 When a shift occurs with cnt_o == WIDTH-1, cnt_o SHALL wrap to 0 and frame_o SHALL be 1 for exactly that cycle.
REQ-017 frame_o SHALL be 0 in every other cycle; back-to-back frames SHALL give pulses exactly WIDTH cycles apart.
REQ-018 Modes LOAD and CLEAR SHALL set cnt_o to 0 and frame_o to 0.
REQ-019 Mode hold with en_i=1 SHALL leave sr_o and cnt_o unchanged and SHALL set frame_o to 0.
REQ-020 Frame counting SHALL be mode-agnostic: mixed shift directions within one frame all count toward it.
REQ-021 The design SHALL contain no latches, and every mode_i value SHALL be decoded.

Reset
REQ-022 With reset=0 at a rising edge, the next state SHALL be sr_o=0, cnt_o=0 and frame_o=0, so that ser_l_o=ser_r_o=0.
REQ-023 Reset SHALL take priority over en_i and mode_i, including in mid-frame and during LOAD.
REQ-024 Outputs SHALL be undefined until the first edge with reset=0; after reset releases, operation SHALL resume at the first edge with reset=1.

Verification (WIDTH=8)
REQ-025 Reset: hold reset=0 for 2 edges with en_i=1 and mode=LOAD, data_i=0xFF -> sr_o=0x00, cnt_o=0, frame_o=0.
REQ-026 Directional shifts: LOAD 0xA5, then SHL with ser_r_i=1 -> 0x4B; LOAD 0xA5, then SHR with ser_l_i=0 -> 0x52; ser_l_o/ser_r_o track sr_o[7]/sr_o[0] in the same cycle.
REQ-027 Rotate and ASR: LOAD 0x81, then ROTL -> 0x03; LOAD 0x81, then ROTR -> 0xC0; LOAD 0x80, then ASR -> 0xC0; each of these sets cnt_o=1.
REQ-028 Frame: CLEAR, then 8 SHL edges with ser_r_i = i%2 (i=0..7) -> sr_o=0x55 and cnt_o=0 after the 8th; frame_o=1 only on the 8th; a 9th SHL gives frame_o=0 and cnt_o=1.
REQ-029 Freeze/hold: at cnt_o=3, drive en_i=0 with mode=SHL for 3 edges, then hold with en_i=1 for 2 edges -> sr_o and cnt_o=3 unchanged, frame_o=0 throughout.
REQ-030 Mid-frame reset: at cnt_o=5 drive reset=0 for 1 edge -> sr_o=0, cnt_o=0; 8 further SHL edges -> exactly one frame_o pulse, on the 8th.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: shift/rotate/load/clear with a per-frame shift counter
// that pulses frame_o each time WIDTH shifts have completed.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic             ser_l_i,
    input  logic             ser_r_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] sr_o,
    output logic             ser_l_o,
    output logic             ser_r_o,
    output logic [CW-1:0]    cnt_o,
    output logic             frame_o
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_SHL   = 3'd1,
        MODE_SHR   = 3'd2,
        MODE_ROTL  = 3'd3,
        MODE_ROTR  = 3'd4,
        MODE_LOAD  = 3'd5,
        MODE_ASR   = 3'd6,
        MODE_CLEAR = 3'd7
    } mode_e;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             frame_q, frame_d;
    logic             shift;

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        shift   = 1'b0;
        if (en_i) begin
            case (mode_e'(mode_i))
                MODE_HOLD:  ;
                MODE_SHL:   begin sr_d = {sr_q[WIDTH-2:0], ser_r_i};  shift = 1'b1; end
                MODE_SHR:   begin sr_d = {ser_l_i, sr_q[WIDTH-1:1]};  shift = 1'b1; end
                MODE_ROTL:  begin sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]}; shift = 1'b1; end
                MODE_ROTR:  begin sr_d = {sr_q[0], sr_q[WIDTH-1:1]};  shift = 1'b1; end
                MODE_LOAD:  begin sr_d = data_i;         cnt_d = '0; end
                MODE_ASR:   begin sr_d = {sr_q[WIDTH-1], sr_q[WIDTH-1:1]}; shift = 1'b1; end
                MODE_CLEAR: begin sr_d = '0;             cnt_d = '0; end
                default:    ;
            endcase
        end
        // Every shift direction counts toward the same frame.
        if (shift) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                frame_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    assign sr_o    = sr_q;
    assign cnt_o   = cnt_q;
    assign frame_o = frame_q;
    assign ser_l_o = sr_q[WIDTH-1];
    assign ser_r_o = sr_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with hand-computed expected values.
module tb_univ_shift_reg;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         en_i;
    logic [2:0]   mode_i;
    logic         ser_l_i;
    logic         ser_r_i;
    logic [W-1:0] data_i;
    logic [W-1:0] sr_o;
    logic         ser_l_o;
    logic         ser_r_o;
    logic [2:0]   cnt_o;
    logic         frame_o;

    int vectors    = 0;
    int miscompares = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en_i),
        .mode_i  (mode_i),
        .ser_l_i (ser_l_i),
        .ser_r_i (ser_r_i),
        .data_i  (data_i),
        .sr_o    (sr_o),
        .ser_l_o (ser_l_o),
        .ser_r_o (ser_r_o),
        .cnt_o   (cnt_o),
        .frame_o (frame_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one edge with the given controls, then sample 1 time unit later.
    task automatic step(input logic en, input logic [2:0] mode, input logic sl, input logic sr);
        en_i    = en;
        mode_i  = mode;
        ser_l_i = sl;
        ser_r_i = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] e_sr,
                             input logic [2:0] e_cnt, input logic e_frame);
        check({tag, ".sr"},    32'(sr_o),    32'(e_sr));
        check({tag, ".cnt"},   32'(cnt_o),   32'(e_cnt));
        check({tag, ".frame"}, 32'(frame_o), 32'(e_frame));
        check({tag, ".ser_l"}, 32'(ser_l_o), 32'(e_sr[W-1]));
        check({tag, ".ser_r"}, 32'(ser_r_o), 32'(e_sr[0]));
    endtask

    initial begin
        logic [W-1:0] exp_sr;
        reset   = 1'b0;
        en_i    = 1'b1;
        mode_i  = 3'd5;
        ser_l_i = 1'b0;
        ser_r_i = 1'b0;
        data_i  = 8'hFF;

        // Reset wins over an enabled LOAD
        step(1'b1, 3'd5, 1'b0, 1'b0);
        step(1'b1, 3'd5, 1'b0, 1'b0);
        check_all("reset", 8'h00, 3'd0, 1'b0);
        reset = 1'b1;

        // Directional shifts
        data_i = 8'hA5;
        step(1'b1, 3'd5, 1'b0, 1'b0);
        check_all("load_a5", 8'hA5, 3'd0, 1'b0);
        step(1'b1, 3'd1, 1'b0, 1'b1);
        check_all("shl", 8'h4B, 3'd1, 1'b0);
        step(1'b1, 3'd5, 1'b0, 1'b0);
        check_all("reload_a5", 8'hA5, 3'd0, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b1);
        check_all("shr", 8'h52, 3'd1, 1'b0);

        // Rotates and arithmetic shift
        data_i = 8'h81;
        step(1'b1, 3'd5, 1'b0, 1'b0);
        step(1'b1, 3'd3, 1'b0, 1'b0);
        check_all("rotl", 8'h03, 3'd1, 1'b0);
        step(1'b1, 3'd5, 1'b0, 1'b0);
        step(1'b1, 3'd4, 1'b0, 1'b0);
        check_all("rotr", 8'hC0, 3'd1, 1'b0);
        data_i = 8'h80;
        step(1'b1, 3'd5, 1'b0, 1'b0);
        step(1'b1, 3'd6, 1'b0, 1'b0);
        check_all("asr", 8'hC0, 3'd1, 1'b0);

        // Frame of 8 SHLs after CLEAR
        step(1'b1, 3'd7, 1'b0, 1'b0);
        check_all("clear", 8'h00, 3'd0, 1'b0);
        exp_sr = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'd1, 1'b0, 1'(i % 2));
            exp_sr = {exp_sr[W-2:0], 1'(i % 2)};
            check_all($sformatf("frame_shl%0d", i), exp_sr, 3'((i + 1) % 8), (i == 7));
        end
        check("frame_value", 32'(sr_o), 32'h55);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        check_all("shl9", 8'hAA, 3'd1, 1'b0);

        // Freeze and hold at cnt=3
        step(1'b1, 3'd1, 1'b0, 1'b1);
        step(1'b1, 3'd1, 1'b0, 1'b1);
        check_all("pre_freeze", 8'hAB, 3'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 3'd1, 1'b1, 1'b1);
            check_all($sformatf("freeze%0d", i), 8'hAB, 3'd3, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 3'd0, 1'b1, 1'b1);
            check_all($sformatf("hold%0d", i), 8'hAB, 3'd3, 1'b0);
        end

        // Mid-frame reset at cnt=5
        step(1'b1, 3'd1, 1'b0, 1'b0);
        step(1'b1, 3'd1, 1'b0, 1'b0);
        check_all("pre_rst", 8'hAC, 3'd5, 1'b0);
        reset = 1'b0;
        step(1'b1, 3'd1, 1'b0, 1'b1);
        check_all("mid_rst", 8'h00, 3'd0, 1'b0);
        reset = 1'b1;
        exp_sr = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'd1, 1'b0, 1'b1);
            exp_sr = {exp_sr[W-2:0], 1'b1};
            check_all($sformatf("post_rst%0d", i), exp_sr, 3'((i + 1) % 8), (i == 7));
        end

        // Mixed directions count toward one frame; en=0 then clears the pulse
        begin
            logic [2:0] mix [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd2, 3'd3};
            for (int i = 0; i < 8; i++) begin
                step(1'b1, mix[i], 1'b0, 1'b0);
                check($sformatf("mix_cnt%0d", i), 32'(cnt_o), 32'((i + 1) % 8));
                check($sformatf("mix_frame%0d", i), 32'(frame_o), 32'(i == 7));
            end
        end
        step(1'b0, 3'd1, 1'b0, 1'b0);
        check("en0_after_frame.frame", 32'(frame_o), 32'd0);
        check("en0_after_frame.cnt", 32'(cnt_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
